// File: rtl/bayer_stream_sequencer.sv
// Sensor timing to coordinate-tagged Bayer stream; frame lock, bounds, line checks.
// Optional BAYER_MEASURE_EN: measure width/height per frame instead of constants.
module bayer_stream_sequencer #(
  parameter int VIDEO_W = 800,
  parameter int VIDEO_H = 600
) (
  input  logic        BAYER_CLK,
  input  logic        reset_n,
  input  logic        SENS_FVAL,
  input  logic        SENS_LVAL,
  input  logic        SENS_DVAL,
  input  logic [11:0] SENS_DATA,
  output logic [11:0] BAYER_X,
  output logic [11:0] BAYER_Y,
  output logic [11:0] BAYER_DATA,
  output logic        BAYER_VALID,
  output logic [11:0] BAYER_WIDTH,
  output logic [11:0] BAYER_HEIGHT,
  output logic        FRAME_START,
  output logic        FRAME_END,
  output logic        LINE_ERR,
  output logic [19:0] FRAME_COUNT
);

  localparam logic [11:0] W12 = VIDEO_W[11:0];
  localparam logic [11:0] H12 = VIDEO_H[11:0];

  typedef enum logic [1:0] {
    SYNC,
    WAIT_FRAME,
    IN_FRAME
  } state_t;

  state_t      state;
  logic        fval_q;
  logic        lval_q;
  logic [11:0] col;
  logic [11:0] row;

  logic        fval_rise;
  logic        fval_fall;
  logic        lval_fall;
  logic        frame_go;
  logic        frame_done;
  logic        pix;
  logic        in_bounds;
  logic        line_end;
  logic [11:0] col_inc;
  logic [11:0] row_nxt;

  assign fval_rise  = SENS_FVAL & ~fval_q;
  assign fval_fall  = ~SENS_FVAL & fval_q;
  assign lval_fall  = ~SENS_LVAL & lval_q;
  assign frame_go   = (state == WAIT_FRAME) & fval_rise;
  assign frame_done = (state == IN_FRAME) & fval_fall;
  assign line_end   = (state == IN_FRAME) & lval_fall;

  // The FVAL rise cycle already carries pixels of the new frame.
  assign pix = ((state == IN_FRAME) | frame_go)
             & SENS_FVAL & SENS_LVAL & SENS_DVAL;

  assign in_bounds = (col < W12) & (row < H12);
  assign col_inc   = (col == 12'hFFF) ? col : col + 12'd1;

  always_comb begin
    row_nxt = row;
    if (line_end && col != 12'd0 && row != 12'hFFF)
      row_nxt = row + 12'd1;
  end

`ifdef BAYER_MEASURE_EN
  logic [11:0] max_col;
  logic [11:0] max_nxt;
  logic [11:0] wid_meas;
  logic [11:0] hgt_meas;

  always_comb begin
    max_nxt = max_col;
    if (line_end && col > max_col)
      max_nxt = col;
  end

  assign wid_meas = (max_nxt > W12) ? W12 : max_nxt;
  assign hgt_meas = (row_nxt > H12) ? H12 : row_nxt;
`endif

  always_ff @(posedge BAYER_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SYNC;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      col          <= '0;
      row          <= '0;
      BAYER_X      <= '0;
      BAYER_Y      <= '0;
      BAYER_DATA   <= '0;
      BAYER_VALID  <= 1'b0;
      BAYER_WIDTH  <= '0;
      BAYER_HEIGHT <= '0;
      FRAME_START  <= 1'b0;
      FRAME_END    <= 1'b0;
      LINE_ERR     <= 1'b0;
      FRAME_COUNT  <= '0;
`ifdef BAYER_MEASURE_EN
      max_col      <= '0;
`endif
    end else begin
      fval_q      <= SENS_FVAL;
      lval_q      <= SENS_LVAL;
      BAYER_VALID <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
`ifndef BAYER_MEASURE_EN
      BAYER_WIDTH  <= W12;
      BAYER_HEIGHT <= H12;
`endif

      unique case (state)
        SYNC: begin
          if (!SENS_FVAL)
            state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (fval_rise)
            state <= IN_FRAME;
        end
        IN_FRAME: begin
          if (fval_fall)
            state <= WAIT_FRAME;
        end
        default: state <= SYNC;
      endcase

      if (pix) begin
        col <= col_inc;
        if (in_bounds) begin
          BAYER_VALID <= 1'b1;
          BAYER_X     <= col;
          BAYER_Y     <= row;
          BAYER_DATA  <= SENS_DATA;
        end
      end

      if (line_end) begin
        col <= '0;
        row <= row_nxt;
        if (col != W12)
          LINE_ERR <= 1'b1;
`ifdef BAYER_MEASURE_EN
        max_col <= max_nxt;
`endif
      end

      if (frame_done) begin
        FRAME_END   <= 1'b1;
        FRAME_COUNT <= FRAME_COUNT + 20'd1;
        row         <= '0;
        col         <= '0;
`ifdef BAYER_MEASURE_EN
        max_col      <= '0;
        BAYER_WIDTH  <= wid_meas;
        BAYER_HEIGHT <= hgt_meas;
`endif
      end

      // A new frame clears the error flag even if a set lands this cycle.
      if (frame_go) begin
        FRAME_START <= 1'b1;
        LINE_ERR    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bayer_stream_sequencer.sv
// Directed bench for bayer_stream_sequencer (VIDEO_W=8, VIDEO_H=4).
// Expectations adapt to whether BAYER_MEASURE_EN is defined.
module tb_bayer_stream_sequencer;

`ifdef BAYER_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fval;
  logic        lval;
  logic        dval;
  logic [11:0] data;
  logic [11:0] bx;
  logic [11:0] by;
  logic [11:0] bdata;
  logic        bvalid;
  logic [11:0] bw;
  logic [11:0] bh;
  logic        fs;
  logic        fe;
  logic        lerr;
  logic [19:0] fcnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bayer_stream_sequencer #(
    .VIDEO_W(8),
    .VIDEO_H(4)
  ) dut (
    .BAYER_CLK   (clk),
    .reset_n     (rst_n),
    .SENS_FVAL   (fval),
    .SENS_LVAL   (lval),
    .SENS_DVAL   (dval),
    .SENS_DATA   (data),
    .BAYER_X     (bx),
    .BAYER_Y     (by),
    .BAYER_DATA  (bdata),
    .BAYER_VALID (bvalid),
    .BAYER_WIDTH (bw),
    .BAYER_HEIGHT(bh),
    .FRAME_START (fs),
    .FRAME_END   (fe),
    .LINE_ERR    (lerr),
    .FRAME_COUNT (fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic l, input logic d,
                     input logic [11:0] px);
    fval = f;
    lval = l;
    dval = d;
    data = px;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    cyc(1, 0, 0, 0);
    chk("frame_start", fs, 1);
    chk("lerr_clear", lerr, 0);
    cyc(1, 0, 0, 0);
    chk("frame_start_pulse", fs, 0);
  endtask

  task automatic do_line(input int n, input int y, input bit toggle,
                         input bit merge_end);
    int          x;
    int          cnt;
    logic        d;
    logic [11:0] px;
    x = 0;
    cnt = toggle ? 2 * n - 1 : n;
    for (int i = 0; i < cnt; i++) begin
      d = toggle ? (i % 2 == 0) : 1'b1;
      px = 12'(y * 32 + x + 3);
      cyc(1, 1, d, px);
      if (d && x < 8 && y < 4) begin
        chk("valid", bvalid, 1);
        chk("x", bx, x);
        chk("y", by, y);
        chk("data", bdata, px);
      end else begin
        chk("drop_valid", bvalid, 0);
      end
      if (d) x++;
    end
    if (!merge_end) begin
      cyc(1, 0, 0, 0);
      chk("gap_valid", bvalid, 0);
    end
  endtask

  task automatic frame_finish(input int cnt);
    cyc(0, 0, 0, 0);
    chk("frame_end", fe, 1);
    chk("frame_count", fcnt, cnt);
    cyc(0, 0, 0, 0);
    chk("frame_end_pulse", fe, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    fval = 0;
    lval = 0;
    dval = 0;
    data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bvalid, 0);
    chk("rst_x", bx, 0);
    chk("rst_y", by, 0);
    chk("rst_data", bdata, 0);
    chk("rst_width", bw, 0);
    chk("rst_height", bh, 0);
    chk("rst_fs", fs, 0);
    chk("rst_fe", fe, 0);
    chk("rst_lerr", lerr, 0);
    chk("rst_count", fcnt, 0);

    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("idle_width", bw, MEAS ? 0 : 8);
    chk("idle_height", bh, MEAS ? 0 : 4);

    // clean 4x8 frame
    frame_begin();
    for (int y = 0; y < 4; y++) do_line(8, y, 0, 0);
    frame_finish(1);
    chk("t1_width", bw, 8);
    chk("t1_height", bh, 4);
    chk("t1_lerr", lerr, 0);

    // reset in the middle of a frame, release with FVAL high
    frame_begin();
    cyc(1, 1, 1, 12'h11);
    cyc(1, 1, 1, 12'h12);
    rst_n = 1'b0;
    cyc(1, 1, 1, 12'h13);
    chk("t2_count_rst", fcnt, 0);
    chk("t2_valid_rst", bvalid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 12'(i + 20));
      chk("t2_valid_sync", bvalid, 0);
    end
    cyc(1, 0, 0, 0);
    chk("t2_lerr", lerr, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 12'(i + 40));
      chk("t2_valid_sync2", bvalid, 0);
    end
    cyc(0, 0, 0, 0);
    chk("t2_no_fe", fe, 0);
    chk("t2_count", fcnt, 0);
    cyc(0, 0, 0, 0);
    chk("t2_width", bw, MEAS ? 0 : 8);

    // DVAL toggling
    frame_begin();
    for (int y = 0; y < 4; y++) do_line(8, y, 1, 0);
    frame_finish(1);
    chk("t5_lerr", lerr, 0);
    chk("t5_width", bw, 8);

    // over-long first line
    frame_begin();
    do_line(10, 0, 0, 0);
    chk("t3_lerr_set", lerr, 1);
    for (int y = 1; y < 4; y++) do_line(8, y, 0, 0);
    frame_finish(2);
    chk("t3_lerr_end", lerr, 1);
    chk("t3_width", bw, 8);
    chk("t3_height", bh, 4);

    // too many lines, then a short one
    frame_begin();
    for (int y = 0; y < 6; y++) do_line(8, y, 0, 0);
    chk("t4_lerr_ok", lerr, 0);
    do_line(6, 6, 0, 0);
    chk("t4_lerr_set", lerr, 1);
    frame_finish(3);
    chk("t4_width", bw, 8);
    chk("t4_height", bh, 4);

    // LVAL and FVAL fall together
    frame_begin();
    for (int y = 0; y < 3; y++) do_line(8, y, 0, 0);
    do_line(8, 3, 0, 1);
    frame_finish(4);
    chk("t6_width", bw, 8);
    chk("t6_height", bh, 4);
    chk("t6_lerr", lerr, 0);

    frame_begin();
    for (int y = 0; y < 2; y++) do_line(5, y, 0, 0);
    do_line(5, 2, 0, 1);
    frame_finish(5);
    chk("t6b_width", bw, MEAS ? 5 : 8);
    chk("t6b_height", bh, MEAS ? 3 : 4);
    chk("t6b_lerr", lerr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
